// File: rtl/worley_pkg.sv
// Shared constants, reset tables and FSM state type for the Worley feature-point animator.
package worley_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int NUM_POINTS = 4;
    localparam int COORD_W    = 10;

    localparam logic [COORD_W-1:0] X_MAX = 10'd639;
    localparam logic [COORD_W-1:0] Y_MAX = 10'd479;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Reset coordinate tables; points beyond the table start at the origin.
    function automatic logic [COORD_W-1:0] init_x(input int i);
        case (i)
            32'sd0:  init_x = 10'd100;
            32'sd1:  init_x = 10'd300;
            32'sd2:  init_x = 10'd500;
            32'sd3:  init_x = 10'd100;
            default: init_x = 10'd0;
        endcase
    endfunction

    function automatic logic [COORD_W-1:0] init_y(input int i);
        case (i)
            32'sd0:  init_y = 10'd100;
            32'sd1:  init_y = 10'd200;
            32'sd2:  init_y = 10'd400;
            32'sd3:  init_y = 10'd460;
            default: init_y = 10'd0;
        endcase
    endfunction

    // Velocity sign tables: 1 means moving towards zero.
    function automatic logic init_vx_neg(input int i);
        case (i)
            32'sd0:  init_vx_neg = 1'b0;
            32'sd1:  init_vx_neg = 1'b1;
            32'sd2:  init_vx_neg = 1'b0;
            32'sd3:  init_vx_neg = 1'b1;
            default: init_vx_neg = 1'b0;
        endcase
    endfunction

    function automatic logic init_vy_neg(input int i);
        case (i)
            32'sd0:  init_vy_neg = 1'b1;
            32'sd1:  init_vy_neg = 1'b0;
            32'sd2:  init_vy_neg = 1'b1;
            32'sd3:  init_vy_neg = 1'b1;
            default: init_vy_neg = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/point_axis_step.sv
// One-axis coordinate step with reflection at 0 and max; purely combinational.
module point_axis_step
    import worley_pkg::*;
(
    input  logic [COORD_W-1:0] coord,
    input  logic               vel_neg,
    input  logic [2:0]         step,
    input  logic [COORD_W-1:0] max,
    output logic [COORD_W-1:0] coord_next,
    output logic               vel_neg_next
);

    localparam int SW = COORD_W + 2;

    logic signed [SW-1:0] c_s;
    logic signed [SW-1:0] d_s;
    logic signed [SW-1:0] m_s;
    logic signed [SW-1:0] n_s;

    assign c_s = signed'({2'b00, coord});
    assign d_s = signed'({{(SW-3){1'b0}}, step});
    assign m_s = signed'({2'b00, max});
    assign n_s = vel_neg ? (c_s - d_s) : (c_s + d_s);

    // Clamp and reflect; landing exactly on a bound keeps the velocity for one more frame.
    always_comb begin
        coord_next   = coord;
        vel_neg_next = vel_neg;
        if (n_s > m_s) begin
            coord_next   = max;
            vel_neg_next = 1'b1;
        end else if (n_s[SW-1]) begin
            coord_next   = {COORD_W{1'b0}};
            vel_neg_next = 1'b0;
        end else begin
            coord_next   = n_s[COORD_W-1:0];
            vel_neg_next = vel_neg;
        end
    end

endmodule

// File: rtl/worley_point_animator.sv
// Steps the feature points one per cycle into shadow registers during blanking,
// then publishes the whole set in a single commit cycle.
module worley_point_animator
    import worley_pkg::*;
#(
    parameter int NUM_POINTS = worley_pkg::NUM_POINTS,
    parameter int COORD_W    = worley_pkg::COORD_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_tick,
    input  logic                          pause,
    input  logic [1:0]                    speed,
    output logic [NUM_POINTS*COORD_W-1:0] points_x,
    output logic [NUM_POINTS*COORD_W-1:0] points_y,
    output logic                          busy,
    output logic [19:0]                   frame_count
);

    localparam int IDX_W = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;

    state_t             state_r;
    state_t             state_n_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_n_s;

    logic [COORD_W-1:0] sx_r [NUM_POINTS];
    logic [COORD_W-1:0] sy_r [NUM_POINTS];
    logic               vx_neg_r [NUM_POINTS];
    logic               vy_neg_r [NUM_POINTS];

    logic [COORD_W-1:0] x_next_s;
    logic [COORD_W-1:0] y_next_s;
    logic               vx_neg_next_s;
    logic               vy_neg_next_s;
    logic [2:0]         step_s;

    assign step_s = {1'b0, speed} + 3'd1;

    point_axis_step u_step_x (
        .coord        (sx_r[idx_r]),
        .vel_neg      (vx_neg_r[idx_r]),
        .step         (step_s),
        .max          (X_MAX),
        .coord_next   (x_next_s),
        .vel_neg_next (vx_neg_next_s)
    );

    point_axis_step u_step_y (
        .coord        (sy_r[idx_r]),
        .vel_neg      (vy_neg_r[idx_r]),
        .step         (step_s),
        .max          (Y_MAX),
        .coord_next   (y_next_s),
        .vel_neg_next (vy_neg_next_s)
    );

    // Next-state and point index sequencing.
    always_comb begin
        state_n_s = state_r;
        idx_n_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_tick && !pause) begin
                    state_n_s = ST_UPDATE;
                    idx_n_s   = {IDX_W{1'b0}};
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                if (idx_r == IDX_W'(NUM_POINTS - 1)) begin
                    state_n_s = ST_COMMIT;
                    idx_n_s   = {IDX_W{1'b0}};
                end else begin
                    idx_n_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_COMMIT: begin
                state_n_s = ST_IDLE;
                idx_n_s   = {IDX_W{1'b0}};
            end
            default: begin
                state_n_s = ST_IDLE;
                idx_n_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, index and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            busy    <= 1'b0;
        end else begin
            state_r <= state_n_s;
            idx_r   <= idx_n_s;
            busy    <= (state_n_s != ST_IDLE);
        end
    end

    // Shadow coordinates and velocities, written one point per UPDATE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                sx_r[i]     <= init_x(i);
                sy_r[i]     <= init_y(i);
                vx_neg_r[i] <= init_vx_neg(i);
                vy_neg_r[i] <= init_vy_neg(i);
            end
        end else if (state_r == ST_UPDATE) begin
            sx_r[idx_r]     <= x_next_s;
            sy_r[idx_r]     <= y_next_s;
            vx_neg_r[idx_r] <= vx_neg_next_s;
            vy_neg_r[idx_r] <= vy_neg_next_s;
        end
    end

    // Visible outputs change only in COMMIT so a frame never sees a mixed set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                points_x[i*COORD_W +: COORD_W] <= init_x(i);
                points_y[i*COORD_W +: COORD_W] <= init_y(i);
            end
            frame_count <= 20'd0;
        end else if (state_r == ST_COMMIT) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                points_x[i*COORD_W +: COORD_W] <= sx_r[i];
                points_y[i*COORD_W +: COORD_W] <= sy_r[i];
            end
            frame_count <= frame_count + 20'd1;
        end
    end

endmodule

// File: tb/tb_worley_point_animator.sv
// Directed bench for worley_point_animator with hand-computed coordinate expectations.
module tb_worley_point_animator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        pause;
    logic [1:0]  speed;
    logic [39:0] points_x;
    logic [39:0] points_y;
    logic        busy;
    logic [19:0] frame_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    worley_point_animator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .pause       (pause),
        .speed       (speed),
        .points_x    (points_x),
        .points_y    (points_y),
        .busy        (busy),
        .frame_count (frame_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_x(input int i);
        return {22'd0, points_x[i*10 +: 10]};
    endfunction

    function automatic logic [31:0] get_y(input int i);
        return {22'd0, points_y[i*10 +: 10]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pt(input string tag, input int i, input int ex, input int ey);
        check_val($sformatf("%s_p%0d_x", tag, i), get_x(i), ex);
        check_val($sformatf("%s_p%0d_y", tag, i), get_y(i), ey);
    endtask

    task automatic check_reset_table(input string tag);
        check_pt(tag, 0, 100, 100);
        check_pt(tag, 1, 300, 200);
        check_pt(tag, 2, 500, 400);
        check_pt(tag, 3, 100, 460);
    endtask

    task automatic run_frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        pause      = 1'b0;
        speed      = 2'd0;
        step();
        step();
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_fc", {12'd0, frame_count}, 32'd0);
        check_reset_table("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single frame at speed 0; outputs must hold until the commit edge.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_val("f1_busy_k", {31'd0, busy}, 32'd1);
        check_pt("f1_k", 0, 100, 100);
        for (int e = 1; e <= 4; e++) begin
            step();
            check_val($sformatf("f1_busy_k%0d", e), {31'd0, busy}, 32'd1);
            check_pt($sformatf("f1_hold_k%0d", e), 0, 100, 100);
            check_pt($sformatf("f1_hold_k%0d", e), 1, 300, 200);
            check_val($sformatf("f1_fc_k%0d", e), {12'd0, frame_count}, 32'd0);
        end
        step();
        check_val("f1_busy_k5", {31'd0, busy}, 32'd0);
        check_val("f1_fc", {12'd0, frame_count}, 32'd1);
        check_pt("f1", 0, 101, 99);
        check_pt("f1", 1, 299, 201);
        check_pt("f1", 2, 501, 399);
        check_pt("f1", 3, 99, 459);

        // A tick arriving while busy is dropped, not queued.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (3) step();
        check_val("drop_fc", {12'd0, frame_count}, 32'd2);
        check_val("drop_busy", {31'd0, busy}, 32'd0);
        step();
        check_val("drop_noqueue", {31'd0, busy}, 32'd0);
        check_pt("drop", 0, 102, 98);

        // Paused tick leaves everything alone.
        pause      = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_val("pause_busy", {31'd0, busy}, 32'd0);
        repeat (5) step();
        check_val("pause_fc", {12'd0, frame_count}, 32'd2);
        check_pt("pause", 0, 102, 98);
        pause = 1'b0;

        // Reset mid-UPDATE, before edge k+3.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mrst_busy", {31'd0, busy}, 32'd0);
        check_val("mrst_fc", {12'd0, frame_count}, 32'd0);
        check_reset_table("mrst");
        step();
        step();
        check_val("mrst_fc_hold", {12'd0, frame_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Speed 4 bounce: lower bound with deferred flip, then upper bound.
        speed = 2'd3;
        repeat (25) run_frame();
        check_val("b25_p3x", get_x(3), 0);
        check_val("b25_p0y", get_y(0), 0);
        check_val("b25_p2x", get_x(2), 600);
        run_frame();
        check_val("b26_p3x", get_x(3), 0);
        check_val("b26_p0y", get_y(0), 0);
        run_frame();
        check_val("b27_p3x", get_x(3), 4);
        check_val("b27_p0y", get_y(0), 4);
        repeat (8) run_frame();
        check_val("b35_p2x", get_x(2), 639);
        run_frame();
        check_val("b36_p2x", get_x(2), 635);
        check_val("b36_fc", {12'd0, frame_count}, 32'd36);
        check_pt("b36", 1, 156, 344);

        // Speed change and pause mid-sequence: only points 2 and 3 see speed 4.
        @(negedge clk);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        speed = 2'd0;
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();
        speed = 2'd3;
        pause = 1'b1;
        repeat (3) step();
        check_val("mid_busy", {31'd0, busy}, 32'd0);
        check_val("mid_fc", {12'd0, frame_count}, 32'd1);
        check_pt("mid", 0, 101, 99);
        check_pt("mid", 1, 299, 201);
        check_pt("mid", 2, 504, 396);
        check_pt("mid", 3, 96, 456);
        pause = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
